// File: rtl/efm_frame_decoder.sv
// efm_frame_decoder: serial EFM channel-bit frame decoder.
// Recovers channel bits (optional NRZI), hunts for the 24-bit frame sync,
// qualifies lock over several frames, flywheels through missed syncs, slices
// each frame into 14-bit symbols, decodes them to bytes and flags run-length
// violations with a saturating error counter.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_bit_valid     qualifies i_bit; nothing advances while low
//   i_bit           channel level (NRZI=1) or channel bit (NRZI=0), MSB first
//   o_data          decoded byte                      (valid with o_data_valid)
//   o_data_valid    one-cycle strobe per decoded symbol
//   o_sym_idx       symbol index within the frame      (valid with o_data_valid)
//   o_s0_sync       symbol is the subcode S0 pattern   (valid with o_data_valid)
//   o_s1_sync       symbol is the subcode S1 pattern   (valid with o_data_valid)
//   o_sym_err       run-length violation in the symbol (valid with o_data_valid)
//   o_frame_start   one-cycle pulse at each frame boundary outside HUNT
//   o_locked        high while in LOCK
//   o_err_cnt       saturating count of o_sym_err strobes

// Combinational EFM symbol table: 14-bit codeword to byte plus S0/S1 flags.
// Holds data bytes 0x00-0x1F; any other codeword decodes to 0x00.
module efm_lut_decode (
    input  logic [13:0] sym_i,
    output logic [7:0]  data_o,
    output logic        s0_o,
    output logic        s1_o
);
    always_comb begin
        data_o = 8'h00;
        s0_o   = 1'b0;
        s1_o   = 1'b0;
        unique case (sym_i)
            14'b01001000100000: data_o = 8'h00;
            14'b10000100000000: data_o = 8'h01;
            14'b10010000100000: data_o = 8'h02;
            14'b10001000100000: data_o = 8'h03;
            14'b01000100000000: data_o = 8'h04;
            14'b00000100010000: data_o = 8'h05;
            14'b00010000100000: data_o = 8'h06;
            14'b00100100000000: data_o = 8'h07;
            14'b01001001000000: data_o = 8'h08;
            14'b10000001000000: data_o = 8'h09;
            14'b10010001000000: data_o = 8'h0A;
            14'b10001001000000: data_o = 8'h0B;
            14'b01000001000000: data_o = 8'h0C;
            14'b00000001000000: data_o = 8'h0D;
            14'b00010001000000: data_o = 8'h0E;
            14'b00100001000000: data_o = 8'h0F;
            14'b10000000100000: data_o = 8'h10;
            14'b10000010000000: data_o = 8'h11;
            14'b10010010000000: data_o = 8'h12;
            14'b00100000100000: data_o = 8'h13;
            14'b01000010000000: data_o = 8'h14;
            14'b00000010000000: data_o = 8'h15;
            14'b00010010000000: data_o = 8'h16;
            14'b00100010000000: data_o = 8'h17;
            14'b01001000010000: data_o = 8'h18;
            14'b10000000010000: data_o = 8'h19;
            14'b10010000010000: data_o = 8'h1A;
            14'b10001000010000: data_o = 8'h1B;
            14'b01000000010000: data_o = 8'h1C;
            14'b00001000010000: data_o = 8'h1D;
            14'b00010000010000: data_o = 8'h1E;
            14'b00100000010000: data_o = 8'h1F;
            14'b00100000000001: s0_o   = 1'b1;
            14'b00000000010010: s1_o   = 1'b1;
            default:            data_o = 8'h00;
        endcase
    end
endmodule

module efm_frame_decoder #(
    parameter int unsigned NRZI          = 1,
    parameter int unsigned SYMS          = 33,
    parameter int unsigned LOCK_FRAMES   = 3,
    parameter int unsigned UNLOCK_FRAMES = 3,
    parameter int unsigned ERR_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_bit_valid,
    input  logic             i_bit,
    output logic [7:0]       o_data,
    output logic             o_data_valid,
    output logic [5:0]       o_sym_idx,
    output logic             o_s0_sync,
    output logic             o_s1_sync,
    output logic             o_sym_err,
    output logic             o_frame_start,
    output logic             o_locked,
    output logic [ERR_W-1:0] o_err_cnt
);
    localparam int unsigned FRAME_BITS = 27 + 17 * SYMS;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
    localparam int unsigned SLOT_W     = 5;
    localparam int unsigned SYM_W      = 7;
    localparam int unsigned GOOD_W     = $clog2(LOCK_FRAMES + 1);
    localparam int unsigned MISS_W     = $clog2(UNLOCK_FRAMES + 1);
    localparam logic [23:0] SYNC_WORD  = 24'h801002;

    typedef enum logic [1:0] {ST_HUNT, ST_CHECK, ST_LOCK} state_e;

    state_e              state_q, state_d;
    logic                prev_q, prev_d;
    logic [22:0]         sh_q, sh_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [SYM_W-1:0]    sym_q, sym_d;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic [7:0]          data_q, data_d;
    logic                dv_q, dv_d;
    logic [5:0]          idx_q, idx_d;
    logic                s0_q, s0_d;
    logic                s1_q, s1_d;
    logic                err_q, err_d;
    logic                fs_q, fs_d;
    logic                locked_q, locked_d;
    logic [ERR_W-1:0]    errcnt_q, errcnt_d;

    logic                ch_bit;
    logic [23:0]         window;
    logic                sync_hit;
    logic [CNT_W-1:0]    cnt_inc;
    logic [SLOT_W-1:0]   slot_inc;
    logic [GOOD_W-1:0]   good_inc;
    logic [MISS_W-1:0]   miss_inc;
    logic [7:0]          lut_data;
    logic                lut_s0;
    logic                lut_s1;
    logic                sym_bad;

    // Run-length rule: 1s need >=2 zeros between them, and no zero run >10.
    function automatic logic rl_err(input logic [13:0] s);
        logic e;
        e = 1'b0;
        for (int i = 0; i < 13; i++) if (s[i] && s[i+1]) e = 1'b1;
        for (int i = 0; i < 12; i++) if (s[i] && s[i+2]) e = 1'b1;
        for (int i = 0; i < 4; i++) if (s[i +: 11] == 11'd0) e = 1'b1;
        return e;
    endfunction

    // Channel bit recovery and the 24-bit window including the incoming bit.
    assign ch_bit   = (NRZI != 0) ? (i_bit ^ prev_q) : i_bit;
    assign window   = {sh_q, ch_bit};
    assign sync_hit = (window == SYNC_WORD);
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign slot_inc = slot_q + SLOT_W'(1);
    assign good_inc = good_q + GOOD_W'(1);
    assign miss_inc = miss_q + MISS_W'(1);
    assign sym_bad  = rl_err(window[13:0]);

    efm_lut_decode u_lut (
        .sym_i  (window[13:0]),
        .data_o (lut_data),
        .s0_o   (lut_s0),
        .s1_o   (lut_s1)
    );

    // Next-state: sync hunt/qualify/flywheel and symbol slicing.
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        slot_d   = slot_q;
        sym_d    = sym_q;
        good_d   = good_q;
        miss_d   = miss_q;
        data_d   = data_q;
        dv_d     = 1'b0;
        idx_d    = idx_q;
        s0_d     = s0_q;
        s1_d     = s1_q;
        err_d    = err_q;
        fs_d     = 1'b0;
        errcnt_d = errcnt_q;

        if (i_bit_valid) begin
            prev_d = i_bit;
            sh_d   = window[22:0];
            unique case (state_q)
                ST_HUNT: begin
                    if (sync_hit) begin
                        cnt_d   = '0;
                        slot_d  = '0;
                        sym_d   = '0;
                        good_d  = GOOD_W'(1);
                        miss_d  = '0;
                        state_d = (LOCK_FRAMES <= 1) ? ST_LOCK : ST_CHECK;
                    end
                end
                ST_CHECK, ST_LOCK: begin
                    cnt_d  = cnt_inc;
                    slot_d = slot_inc;
                    // Every 17 bits closes a symbol (14 code bits + 3 merging).
                    if (slot_inc == SLOT_W'(17)) begin
                        slot_d = '0;
                        sym_d  = sym_q + SYM_W'(1);
                        if (sym_q < SYM_W'(SYMS)) begin
                            dv_d   = 1'b1;
                            idx_d  = 6'(sym_q);
                            data_d = lut_data;
                            s0_d   = lut_s0;
                            s1_d   = lut_s1;
                            err_d  = sym_bad;
                            if (sym_bad && (errcnt_q != {ERR_W{1'b1}})) begin
                                errcnt_d = errcnt_q + ERR_W'(1);
                            end
                        end
                    end
                    if (cnt_inc == CNT_W'(FRAME_BITS)) begin
                        cnt_d  = '0;
                        slot_d = '0;
                        sym_d  = '0;
                        if (state_q == ST_CHECK) begin
                            if (sync_hit) begin
                                good_d = good_inc;
                                fs_d   = 1'b1;
                                if (good_inc == GOOD_W'(LOCK_FRAMES)) state_d = ST_LOCK;
                            end else begin
                                state_d = ST_HUNT;
                            end
                        end else begin
                            // Flywheel: keep frame timing even on a missed sync.
                            fs_d = 1'b1;
                            if (sync_hit) begin
                                miss_d = '0;
                            end else begin
                                miss_d = miss_inc;
                                if (miss_inc == MISS_W'(UNLOCK_FRAMES)) state_d = ST_HUNT;
                            end
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        locked_d = (state_d == ST_LOCK);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_HUNT;
            prev_q   <= 1'b0;
            sh_q     <= '0;
            cnt_q    <= '0;
            slot_q   <= '0;
            sym_q    <= '0;
            good_q   <= '0;
            miss_q   <= '0;
            data_q   <= '0;
            dv_q     <= 1'b0;
            idx_q    <= '0;
            s0_q     <= 1'b0;
            s1_q     <= 1'b0;
            err_q    <= 1'b0;
            fs_q     <= 1'b0;
            locked_q <= 1'b0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            slot_q   <= slot_d;
            sym_q    <= sym_d;
            good_q   <= good_d;
            miss_q   <= miss_d;
            data_q   <= data_d;
            dv_q     <= dv_d;
            idx_q    <= idx_d;
            s0_q     <= s0_d;
            s1_q     <= s1_d;
            err_q    <= err_d;
            fs_q     <= fs_d;
            locked_q <= locked_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign o_data        = data_q;
    assign o_data_valid  = dv_q;
    assign o_sym_idx     = idx_q;
    assign o_s0_sync     = s0_q;
    assign o_s1_sync     = s1_q;
    assign o_sym_err     = err_q;
    assign o_frame_start = fs_q;
    assign o_locked      = locked_q;
    assign o_err_cnt     = errcnt_q;

endmodule

// File: tb/tb_efm_frame_decoder.sv
// Bench for efm_frame_decoder: two instances (NRZI level input and raw
// channel-bit input) fed equivalent streams, checked every cycle against a
// frame-level reference model built from the channel-bit stream.
module tb_efm_frame_decoder;
    localparam int SYMS = 33;
    localparam int LOCK_FRAMES = 3;
    localparam int UNLOCK_FRAMES = 3;
    localparam int FRAME_BITS = 27 + 17 * SYMS;
    localparam int MAXN = 8000;
    localparam logic [23:0] SYNC = 24'h801002;
    localparam logic [13:0] C_S0  = 14'b00100000000001;
    localparam logic [13:0] C_S1  = 14'b00000000010010;
    localparam logic [13:0] C_D00 = 14'b01001000100000;
    localparam logic [13:0] C_D01 = 14'b10000100000000;
    localparam logic [13:0] C_BAD = 14'b11000000000000;

    logic clk, rst, bit_valid, bit_raw, bit_lvl;
    logic [7:0]  n_data, r_data;
    logic        n_dv, r_dv, n_s0, r_s0, n_s1, r_s1, n_err, r_err, n_fs, r_fs, n_lk, r_lk;
    logic [5:0]  n_idx, r_idx;
    logic [15:0] n_cnt, r_cnt;

    efm_frame_decoder #(.NRZI(1), .SYMS(SYMS), .LOCK_FRAMES(LOCK_FRAMES),
                        .UNLOCK_FRAMES(UNLOCK_FRAMES), .ERR_W(16)) dut (
        .clk(clk), .rst(rst), .i_bit_valid(bit_valid), .i_bit(bit_lvl),
        .o_data(n_data), .o_data_valid(n_dv), .o_sym_idx(n_idx), .o_s0_sync(n_s0),
        .o_s1_sync(n_s1), .o_sym_err(n_err), .o_frame_start(n_fs), .o_locked(n_lk),
        .o_err_cnt(n_cnt));

    efm_frame_decoder #(.NRZI(0), .SYMS(SYMS), .LOCK_FRAMES(LOCK_FRAMES),
                        .UNLOCK_FRAMES(UNLOCK_FRAMES), .ERR_W(16)) dut_raw (
        .clk(clk), .rst(rst), .i_bit_valid(bit_valid), .i_bit(bit_raw),
        .o_data(r_data), .o_data_valid(r_dv), .o_sym_idx(r_idx), .o_s0_sync(r_s0),
        .o_s1_sync(r_s1), .o_sym_err(r_err), .o_frame_start(r_fs), .o_locked(r_lk),
        .o_err_cnt(r_cnt));

    // Stream and reference model arrays, indexed by channel-bit position.
    bit         ch[MAXN];
    bit         m_sv[MAXN], m_fs[MAXN], m_lk[MAXN], m_s0[MAXN], m_s1[MAXN], m_er[MAXN], m_dk[MAXN];
    logic [7:0] m_dat[MAXN];
    int         m_idx[MAXN];
    int         N;
    int         sync_pos[16];

    int  n_err_cnt = 0, n_chk = 0;
    bit  drv_valid, chk_en;
    int  drv_n;
    int  rec_sel;
    logic [13:0] rec0[$], rec1[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err_cnt++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, act, exp);
        end
    endtask

    task automatic push(input bit b);
        ch[N] = b;
        N++;
    endtask

    task automatic push_word(input logic [23:0] w, input int len);
        for (int i = len - 1; i >= 0; i--) push(w[i]);
    endtask

    function automatic logic [13:0] sym_code(input int f, input int k);
        if (k == 0) return (f % 2 == 0) ? C_S0 : C_S1;
        if (k == 1) return C_D00;
        if (k == 2) return C_D01;
        if (k == 3) return (f % 3 == 1) ? C_BAD : C_D00;
        return (k % 2 == 1) ? C_D01 : C_D00;
    endfunction

    // Preamble, nf frames (sync + merging + symbols), trailing sync, postamble.
    task automatic build_stream(input int nf, input logic [15:0] corrupt);
        logic [23:0] w;
        N = 0;
        for (int i = 0; i < 20; i++) push(1'b0);
        for (int f = 0; f <= nf; f++) begin
            w = SYNC;
            if (corrupt[f]) w[12] = 1'b0;
            push_word(w, 24);
            sync_pos[f] = N - 1;
            if (f < nf) begin
                for (int i = 0; i < 3; i++) push(1'b0);
                for (int k = 0; k < SYMS; k++) begin
                    push_word(24'(sym_code(f, k)), 14);
                    for (int i = 0; i < 3; i++) push(1'b0);
                end
            end
        end
        for (int i = 0; i < 20; i++) push(1'b0);
    endtask

    function automatic bit sync_at(input int n);
        logic [23:0] s;
        s = SYNC;
        if (n < 23) return 1'b0;
        for (int j = 0; j < 24; j++) if (ch[n - 23 + j] != s[23 - j]) return 1'b0;
        return 1'b1;
    endfunction

    // Walk the ones of the codeword and measure every zero run.
    function automatic bit rl_bad(input logic [13:0] w);
        int last, run, ones;
        bit bad;
        last = -1; run = 0; ones = 0; bad = 1'b0;
        for (int j = 13; j >= 0; j--) begin
            if (w[j]) begin
                ones++;
                if (last >= 0 && (last - j - 1) < 2) bad = 1'b1;
                last = j;
                run = 0;
            end else begin
                run++;
                if (run > 10) bad = 1'b1;
            end
        end
        if (ones == 0) bad = 1'b1;
        return bad;
    endfunction

    task automatic decode_sym(input int pos, input int k);
        logic [13:0] w;
        w = '0;
        for (int j = 0; j < 14; j++) w = {w[12:0], ch[pos - 13 + j]};
        m_sv[pos] = 1'b1;
        m_idx[pos] = k;
        m_er[pos] = rl_bad(w);
        m_s0[pos] = (w == C_S0);
        m_s1[pos] = (w == C_S1);
        m_dk[pos] = (w == C_D00) || (w == C_D01);
        m_dat[pos] = (w == C_D01) ? 8'h01 : 8'h00;
    endtask

    // Frame-level reference: find a sync, then step whole frames at a time.
    task automatic build_model();
        int p, a, b, good, miss, pos;
        bit lkv, in_frame;
        for (int n = 0; n < MAXN; n++) begin
            m_sv[n] = 0; m_fs[n] = 0; m_lk[n] = 0; m_s0[n] = 0; m_s1[n] = 0;
            m_er[n] = 0; m_dk[n] = 0; m_dat[n] = 0; m_idx[n] = 0;
        end
        p = 23;
        while (p < N) begin
            a = -1;
            for (int n = p; n < N; n++) if (a < 0 && sync_at(n)) a = n;
            if (a < 0) begin
                p = N;
            end else begin
                good = 1; miss = 0;
                lkv = (LOCK_FRAMES <= 1);
                m_lk[a] = lkv;
                in_frame = 1'b1;
                while (in_frame) begin
                    for (int k = 0; k < SYMS; k++) begin
                        pos = a + 17 * (k + 1);
                        if (pos < N) decode_sym(pos, k);
                    end
                    b = a + FRAME_BITS;
                    for (int n = a + 1; n < b && n < N; n++) m_lk[n] = lkv;
                    if (b >= N) begin
                        in_frame = 1'b0; p = N;
                    end else if (sync_at(b)) begin
                        m_fs[b] = 1'b1;
                        if (lkv) miss = 0;
                        else begin good++; if (good >= LOCK_FRAMES) lkv = 1'b1; end
                        m_lk[b] = lkv; a = b;
                    end else if (!lkv) begin
                        in_frame = 1'b0; p = b + 1;
                    end else begin
                        m_fs[b] = 1'b1;
                        miss++;
                        if (miss >= UNLOCK_FRAMES) begin lkv = 1'b0; in_frame = 1'b0; p = b + 1; end
                        m_lk[b] = lkv; a = b;
                    end
                end
            end
        end
    endtask

    task automatic check_zero(input string tg);
        cmp({tg, ".nrzi.outs"}, int'({n_data, n_dv, n_idx, n_s0, n_s1, n_err, n_fs, n_lk}), 0);
        cmp({tg, ".nrzi.err_cnt"}, int'(n_cnt), 0);
        cmp({tg, ".raw.outs"}, int'({r_data, r_dv, r_idx, r_s0, r_s1, r_err, r_fs, r_lk}), 0);
        cmp({tg, ".raw.err_cnt"}, int'(r_cnt), 0);
    endtask

    task automatic run_stream(input int nbits, input bit gaps, input int rec);
        int lvl;
        lvl = 0;
        rec_sel = rec;
        for (int n = 0; n < nbits; n++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 4)) begin
                    @(negedge clk);
                    chk_en = 1'b1; bit_valid = 1'b0; drv_valid = 1'b0;
                    bit_raw = 1'($urandom); bit_lvl = 1'($urandom);
                end
            end
            @(negedge clk);
            lvl = lvl ^ int'(ch[n]);
            chk_en = 1'b1; bit_valid = 1'b1; drv_valid = 1'b1; drv_n = n;
            bit_raw = ch[n]; bit_lvl = 1'(lvl);
        end
        @(negedge clk);
        bit_valid = 1'b0; drv_valid = 1'b0;
    endtask

    task automatic do_reset(input string tg);
        @(negedge clk);
        chk_en = 1'b0; rst = 1'b1; bit_valid = 1'b1; bit_raw = 1'b1; bit_lvl = 1'b1;
        repeat (2) @(negedge clk);
        check_zero(tg);
        rst = 1'b0; bit_valid = 1'b0;
    endtask

    // Per-cycle compare of both instances against the model.
    bit cv, ce, lk_m;
    int cn, err_m;

    task automatic check_one(input string tg, input logic dv, input logic [7:0] d,
                             input logic [5:0] ix, input logic s0, input logic s1,
                             input logic er, input logic fs, input logic lk,
                             input logic [15:0] ec);
        bit edv;
        edv = cv && m_sv[cn];
        cmp({tg, ".data_valid"}, int'(dv), int'(edv));
        cmp({tg, ".frame_start"}, int'(fs), int'(cv && m_fs[cn]));
        cmp({tg, ".locked"}, int'(lk), int'(lk_m));
        cmp({tg, ".err_cnt"}, int'(ec), err_m);
        if (edv) begin
            cmp({tg, ".sym_idx"}, int'(ix), m_idx[cn]);
            cmp({tg, ".s0"}, int'(s0), int'(m_s0[cn]));
            cmp({tg, ".s1"}, int'(s1), int'(m_s1[cn]));
            cmp({tg, ".sym_err"}, int'(er), int'(m_er[cn]));
            if (m_dk[cn]) cmp({tg, ".data"}, int'(d), int'(m_dat[cn]));
        end
    endtask

    initial begin : compare
        forever begin
            @(posedge clk);
            cv = drv_valid; cn = drv_n; ce = chk_en;
            #1;
            if (!ce) begin
                lk_m = 1'b0; err_m = 0;
            end else begin
                if (cv) begin
                    lk_m = m_lk[cn];
                    if (m_sv[cn] && m_er[cn] && err_m < 65535) err_m++;
                end
                check_one("nrzi", n_dv, n_data, n_idx, n_s0, n_s1, n_err, n_fs, n_lk, n_cnt);
                check_one("raw", r_dv, r_data, r_idx, r_s0, r_s1, r_err, r_fs, r_lk, r_cnt);
                if (n_dv && rec_sel == 0) rec0.push_back({n_idx, n_data});
                if (n_dv && rec_sel == 1) rec1.push_back({n_idx, n_data});
            end
        end
    end

    initial begin : stim
        int cnt, ndiff, sp0;
        rst = 1'b1; bit_valid = 1'b0; bit_raw = 1'b0; bit_lvl = 1'b0;
        chk_en = 1'b0; drv_valid = 1'b0; drv_n = 0; rec_sel = 2;
        repeat (3) @(negedge clk);
        check_zero("por");
        rst = 1'b0;

        // Partial stream into the second frame, then reset mid-frame.
        build_stream(2, 16'h0);
        build_model();
        run_stream(sync_pos[1] + 200, 1'b0, 2);
        do_reset("mid_reset");

        // Acquire, flywheel over 2 misses, unlock on 3, reacquire.
        build_stream(13, 16'b0000_0111_0110_0000);
        build_model();
        sp0 = sync_pos[0];
        cnt = 0;
        for (int n = sp0 + 1; n <= sync_pos[1]; n++) cnt += int'(m_sv[n]);
        cmp("model.syms_per_frame", cnt, 33);
        cmp("model.sym0_s0", int'(m_s0[sp0 + 17]) + 2 * m_idx[sp0 + 17], 1);
        cmp("model.sym1_data", int'(m_dat[sp0 + 34]) + 256 * int'(m_dk[sp0 + 34]), 256);
        cmp("model.sym2_data", int'(m_dat[sp0 + 51]) + 2 * int'(m_er[sp0 + 51]), 1);
        cmp("model.sym3_err", int'(m_er[sync_pos[1] + 68]), 1);
        cmp("model.lock_before", int'(m_lk[sync_pos[2] - 1]), 0);
        cmp("model.lock_at_3rd", int'(m_lk[sync_pos[2]]), 1);
        cmp("model.flywheel_fs", int'(m_fs[sync_pos[6]]) + 2 * int'(m_lk[sync_pos[9]]), 3);
        cmp("model.unlock", int'(m_lk[sync_pos[10]]), 0);
        cnt = 0;
        for (int n = sync_pos[10] + 1; n <= sync_pos[11]; n++) cnt += int'(m_sv[n]);
        cmp("model.no_strobes_hunt", cnt, 0);

        run_stream(N, 1'b0, 0);
        do_reset("reset_b");
        run_stream(N, 1'b1, 1);
        do_reset("reset_c");

        ndiff = 0;
        for (int i = 0; i < rec0.size() && i < rec1.size(); i++)
            if (rec0[i] != rec1[i]) ndiff++;
        cmp("gap_seq_len", rec1.size(), rec0.size());
        cmp("gap_seq_diff", ndiff, 0);

        $display("Result: errors=%0d of %0d checks", n_err_cnt, n_chk);
        $finish;
    end
endmodule
